// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Data has priority over fetch; a burst limit forces a fetch so it cannot starve.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 16,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              bus_err,
    output logic [1:0]        dbg_state
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int BST_W = $clog2(MAX_D_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;  // 1 = data, 0 = fetch
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BST_W-1:0]    burst_q, burst_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                bus_err_q, bus_err_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic                grant_data;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        burst_d    = burst_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        bus_err_d  = 1'b0;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        grant_data = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    grant_data = d_req && !(if_req && burst_q == BST_W'(MAX_D_BURST));
                    owner_d    = grant_data;
                    addr_d     = grant_data ? d_addr : if_addr;
                    we_d       = grant_data && d_we;
                    wdata_d    = grant_data ? d_wdata : '0;
                    if (grant_data && if_req) begin
                        if (burst_q != BST_W'(MAX_D_BURST)) burst_d = burst_q + 1'b1;
                    end else begin
                        burst_d = '0;
                    end
                    // Misaligned data access never reaches memory.
                    if (grant_data && d_addr[1:0] != 2'b00) begin
                        state_d   = S_DONE;
                        err_d     = 1'b1;
                        d_ack_d   = 1'b1;
                        bus_err_d = 1'b1;
                    end else begin
                        state_d  = S_ACCESS;
                        mem_en_d = 1'b1;
                        mem_we_d = grant_data && d_we;
                    end
                end
            end
            S_ACCESS: begin
                tmo_d    = tmo_q + 1'b1;
                mem_en_d = 1'b1;
                mem_we_d = we_q;
                if (mem_ready || tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    mem_en_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    if_ack_d  = !owner_q;
                    d_ack_d   = owner_q;
                    err_d     = !mem_ready;
                    bus_err_d = !mem_ready;
                    if (!mem_ready) begin
                        if (owner_q) d_rdata_d = '0;
                        else         if_rdata_d = '0;
                    end else if (!we_q) begin
                        if (owner_q) d_rdata_d = mem_rdata;
                        else         if_rdata_d = mem_rdata;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                tmo_d   = '0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            burst_q    <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            burst_q    <= burst_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            bus_err_q  <= bus_err_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign bus_err   = bus_err_q;
    assign dbg_state = state_q;
    assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a wait-state memory responder plus per-scenario tasks
// whose completions are checked against an expected queue of {owner, err, rdata}.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TMO = 16;
    localparam int MAXB = 4;

    logic clk, rst;
    logic if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic if_ack, d_ack, mem_en, mem_we, stall, bus_err, mem_ready;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [DW+1:0] exp_q[$];

    logic resp_on = 1'b0;
    int mem_wait = 0;
    int resp_cnt = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .MAX_D_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .bus_err(bus_err), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        if (a == 32'h0000_0040) return 32'h2008_0005;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: raises mem_ready after mem_wait cycles of mem_en.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (resp_on && mem_en) begin
                mem_rdata = mem_model(mem_addr);
                mem_ready = (resp_cnt == mem_wait);
                resp_cnt++;
            end else begin
                mem_ready = 1'b0;
                resp_cnt = 0;
            end
        end
    end

    // Issues one request from IDLE and traces it until its ack (cycle 0 = sampling edge).
    task automatic run_req(input logic is_d, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, output int en_first, output int en_cnt,
                           output int we_cnt, output int ack_cyc, output logic stable,
                           output logic [AW-1:0] a0, output logic [DW-1:0] w0,
                           output logic [DW+1:0] obs);
        en_first = -1; en_cnt = 0; we_cnt = 0; ack_cyc = -1; stable = 1'b1;
        a0 = '0; w0 = '0; obs = '0;
        if_req = !is_d; if_addr = addr;
        d_req = is_d; d_we = we; d_addr = addr; d_wdata = wdata;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                if (en_cnt == 0) begin
                    en_first = cyc; a0 = mem_addr; w0 = mem_wdata;
                end else if (mem_addr !== a0 || mem_wdata !== w0) begin
                    stable = 1'b0;
                end
                en_cnt++;
            end
            if (mem_we) we_cnt++;
            if (if_ack || d_ack) begin
                ack_cyc = cyc;
                obs = {d_ack, bus_err, d_ack ? d_rdata : if_rdata};
                break;
            end
        end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        checks++; if ({mem_en, mem_we, if_ack, d_ack, bus_err, stall} !== 6'b0) begin
            errors++; $display("FAIL reset_ctl got %b exp 000000", {mem_en, mem_we, if_ack, d_ack, bus_err, stall});
        end
        checks++; if (if_rdata !== '0 || d_rdata !== '0) begin
            errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", if_rdata, d_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        resp_on = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_wait_fetch;
        int ef, ec, wc, ac; logic st; logic [AW-1:0] a0; logic [DW-1:0] w0; logic [DW+1:0] obs, exp;
        mem_wait = 0;
        exp_q.push_back({1'b0, 1'b0, 32'h2008_0005});
        run_req(1'b0, 1'b0, 32'h0000_0040, '0, ef, ec, wc, ac, st, a0, w0, obs);
        exp = exp_q.pop_front();
        checks++; if (ef !== 1 || a0 !== 32'h40) begin errors++; $display("FAIL fetch_en got cyc %0d addr %h exp 1 40", ef, a0); end
        checks++; if (ac !== 2) begin errors++; $display("FAIL fetch_ack_cyc got %0d exp 2", ac); end
        checks++; if (obs !== exp) begin errors++; $display("FAIL fetch_result got %h exp %h", obs, exp); end
    endtask

    task automatic test_store_wait;
        int ef, ec, wc, ac; logic st; logic [AW-1:0] a0; logic [DW-1:0] w0; logic [DW+1:0] obs, exp;
        mem_wait = 0;
        exp_q.push_back({1'b1, 1'b0, mem_model(32'h300)});
        run_req(1'b1, 1'b0, 32'h300, '0, ef, ec, wc, ac, st, a0, w0, obs);
        exp = exp_q.pop_front();
        checks++; if (obs !== exp) begin errors++; $display("FAIL preload got %h exp %h", obs, exp); end
        mem_wait = 3;
        exp_q.push_back({1'b1, 1'b0, mem_model(32'h300)});
        run_req(1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, ef, ec, wc, ac, st, a0, w0, obs);
        exp = exp_q.pop_front();
        checks++; if (ec !== 4 || wc !== 4) begin errors++; $display("FAIL store_en_cnt got %0d/%0d exp 4/4", ec, wc); end
        checks++; if (!st || a0 !== 32'h100 || w0 !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL store_bus got stable %b %h %h exp 1 100 cafef00d", st, a0, w0);
        end
        checks++; if (ac !== 5) begin errors++; $display("FAIL store_ack_cyc got %0d exp 5", ac); end
        checks++; if (obs !== exp) begin errors++; $display("FAIL store_result got %h exp %h", obs, exp); end
    endtask

    task automatic test_misaligned;
        int ef, ec, wc, ac; logic st; logic [AW-1:0] a0; logic [DW-1:0] w0; logic [DW+1:0] obs, exp;
        mem_wait = 0;
        exp_q.push_back({1'b1, 1'b1, mem_model(32'h300)});
        run_req(1'b1, 1'b0, 32'h102, '0, ef, ec, wc, ac, st, a0, w0, obs);
        exp = exp_q.pop_front();
        checks++; if (ec !== 0) begin errors++; $display("FAIL misalign_en got %0d exp 0", ec); end
        checks++; if (ac !== 1) begin errors++; $display("FAIL misalign_ack_cyc got %0d exp 1", ac); end
        checks++; if (obs !== exp) begin errors++; $display("FAIL misalign_result got %h exp %h", obs, exp); end
    endtask

    task automatic test_timeout;
        int ef, ec, wc, ac; logic st; logic [AW-1:0] a0; logic [DW-1:0] w0; logic [DW+1:0] obs, exp;
        mem_wait = 1000;
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        run_req(1'b1, 1'b0, 32'h200, '0, ef, ec, wc, ac, st, a0, w0, obs);
        exp = exp_q.pop_front();
        checks++; if (ec !== TMO) begin errors++; $display("FAIL tmo_en_cnt got %0d exp %0d", ec, TMO); end
        checks++; if (ac !== TMO + 1) begin errors++; $display("FAIL tmo_ack_cyc got %0d exp %0d", ac, TMO + 1); end
        checks++; if (obs !== exp) begin errors++; $display("FAIL tmo_result got %h exp %h", obs, exp); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL tmo_idle got %0d exp 0", dbg_state); end
    endtask

    task automatic test_arbitration;
        logic [DW+1:0] obs, exp;
        int n = 0;
        mem_wait = 1;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) exp_q.push_back({1'b0, 1'b0, mem_model(32'h80)});
            else            exp_q.push_back({1'b1, 1'b0, mem_model(32'h500)});
        end
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        for (int cyc = 0; cyc < 300 && n < 10; cyc++) begin
            @(posedge clk);
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL arb_stall cyc %0d got %b exp 1", cyc, stall); end
            if (if_ack || d_ack) begin
                obs = {d_ack, bus_err, d_ack ? d_rdata : if_rdata};
                exp = exp_q.pop_front();
                n++;
                checks++; if (obs !== exp) begin errors++; $display("FAIL arb_grant %0d got %h exp %h", n, obs, exp); end
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        checks++; if (n !== 10) begin errors++; $display("FAIL arb_count got %0d exp 10", n); exp_q.delete(); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_loads;
        int ef, ec, wc, ac, w; logic st; logic [AW-1:0] a0, addr; logic [DW-1:0] w0; logic [DW+1:0] obs, exp;
        for (int i = 0; i < 4; i++) begin
            w = $urandom_range(0, 3);
            mem_wait = w;
            addr = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
            exp_q.push_back({1'b1, 1'b0, mem_model(addr)});
            run_req(1'b1, 1'b0, addr, '0, ef, ec, wc, ac, st, a0, w0, obs);
            exp = exp_q.pop_front();
            checks++; if (ac !== w + 2 || obs !== exp) begin
                errors++; $display("FAIL rand_load %0d got cyc %0d %h exp cyc %0d %h", i, ac, obs, w + 2, exp);
            end
        end
    endtask

    task automatic test_reset_mid_access;
        int ef, ec, wc, ac; logic st; logic [AW-1:0] a0; logic [DW-1:0] w0; logic [DW+1:0] obs, exp;
        mem_wait = 5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", mem_en); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({mem_en, mem_we, if_ack, d_ack, bus_err} !== 5'b0 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL midrst_async got %b st %0d exp 00000 st 0", {mem_en, mem_we, if_ack, d_ack, bus_err}, dbg_state);
        end
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mem_wait = 0;
        exp_q.push_back({1'b1, 1'b0, mem_model(32'h404)});
        run_req(1'b1, 1'b0, 32'h404, '0, ef, ec, wc, ac, st, a0, w0, obs);
        exp = exp_q.pop_front();
        checks++; if (ac !== 2 || obs !== exp) begin
            errors++; $display("FAIL midrst_after got cyc %0d %h exp cyc 2 %h", ac, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        test_reset();
        test_zero_wait_fetch();
        test_store_wait();
        test_misaligned();
        test_timeout();
        test_arbitration();
        test_random_loads();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
